// File: rtl/ps2_keypad.sv
// PS/2 scan-code stream to 16-key CHIP-8 matrix plus a latched press event (valid/ack).
// Define PS2_KEYPAD_TYPEMATIC_FILTER_EN to suppress press events for auto-repeated make codes.
module ps2_keypad #(
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ps2Ready,
  input  logic [7:0]  ps2Data,
  output logic [15:0] keyMatrix,
  output logic        keyValid,
  output logic [3:0]  keyCode,
  input  logic        keyAck,
  output logic        keyOverrun
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, BRK, EXT, EXT_BRK} state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   ready_d;
  logic [CNT_W-1:0]       tmo_cnt;
  logic                   byte_stb;
  logic                   mapped;
  logic [3:0]             hex;
  logic                   press;

  function automatic logic [4:0] map_key(input logic [7:0] code);
    case (code)
      8'h22: map_key = {1'b1, 4'h0};
      8'h16: map_key = {1'b1, 4'h1};
      8'h1E: map_key = {1'b1, 4'h2};
      8'h26: map_key = {1'b1, 4'h3};
      8'h15: map_key = {1'b1, 4'h4};
      8'h1D: map_key = {1'b1, 4'h5};
      8'h24: map_key = {1'b1, 4'h6};
      8'h1C: map_key = {1'b1, 4'h7};
      8'h1B: map_key = {1'b1, 4'h8};
      8'h23: map_key = {1'b1, 4'h9};
      8'h1A: map_key = {1'b1, 4'hA};
      8'h21: map_key = {1'b1, 4'hB};
      8'h25: map_key = {1'b1, 4'hC};
      8'h2D: map_key = {1'b1, 4'hD};
      8'h2B: map_key = {1'b1, 4'hE};
      8'h2A: map_key = {1'b1, 4'hF};
      default: map_key = 5'h00;
    endcase
  endfunction

  assign {mapped, hex} = map_key(ps2Data);
  assign byte_stb = sync_q[SYNC_STAGES-1] & ~ready_d;

`ifdef PS2_KEYPAD_TYPEMATIC_FILTER_EN
  // A make for a key already held is auto-repeat and raises no event.
  assign press = byte_stb && (state == IDLE) && mapped && !keyMatrix[hex];
`else
  assign press = byte_stb && (state == IDLE) && mapped;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      sync_q     <= '0;
      ready_d    <= 1'b0;
      tmo_cnt    <= '0;
      keyMatrix  <= '0;
      keyValid   <= 1'b0;
      keyCode    <= '0;
      keyOverrun <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
      sync_q  <= {sync_q[SYNC_STAGES-2:0], ps2Ready};
      ready_d <= sync_q[SYNC_STAGES-1];

      if (byte_stb) begin
        tmo_cnt <= '0;
        case (state)
          IDLE: begin
            if (ps2Data == 8'hF0)                         state <= BRK;
            else if (ps2Data == 8'hE0)                    state <= EXT;
            else if (ps2Data == 8'h00 || ps2Data == 8'hFF) keyMatrix <= '0;
            else if (mapped)                              keyMatrix[hex] <= 1'b1;
          end
          BRK: begin
            if (mapped) keyMatrix[hex] <= 1'b0;
            state <= IDLE;
          end
          EXT:     state <= (ps2Data == 8'hF0) ? EXT_BRK : IDLE;
          EXT_BRK: state <= IDLE;
        endcase
      end else if (state != IDLE) begin
        // A stalled prefix is dropped so a lost byte cannot turn the next make into a break.
        if (tmo_cnt == CNT_LAST) begin
          state   <= IDLE;
          tmo_cnt <= '0;
        end else begin
          tmo_cnt <= tmo_cnt + 1'b1;
        end
      end else begin
        tmo_cnt <= '0;
      end

      if (press) begin
        if (!keyValid || keyAck) begin
          keyValid   <= 1'b1;
          keyCode    <= hex;
          keyOverrun <= 1'b0;
        end else begin
          keyOverrun <= 1'b1;
        end
      end else if (keyAck && keyValid) begin
        keyValid   <= 1'b0;
        keyOverrun <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ps2_keypad.sv
// Scoreboard bench for ps2_keypad: a byte-level reference model queues expected press
// events, and a monitor process pops and compares whenever keyValid is presented.
module tb_ps2_keypad;

  localparam int TMO = 200;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ps2Ready;
  logic [7:0]  ps2Data;
  logic [15:0] keyMatrix;
  logic        keyValid;
  logic [3:0]  keyCode;
  logic        keyAck;
  logic        keyOverrun;

  int checks = 0;
  int errors = 0;
  int events_seen = 0;
  bit mon_en = 1'b0;

  int        exp_q[$];
  bit [15:0] m_matrix;
  bit        m_f0, m_e0;
  int        key_of[bit [7:0]];
  bit [7:0]  make_codes[16] = '{8'h22, 8'h16, 8'h1E, 8'h26, 8'h15, 8'h1D, 8'h24, 8'h1C,
                                8'h1B, 8'h23, 8'h1A, 8'h21, 8'h25, 8'h2D, 8'h2B, 8'h2A};

  always #5 clk = ~clk;

  ps2_keypad #(.TIMEOUT_CYCLES(TMO), .SYNC_STAGES(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ps2Ready  (ps2Ready),
    .ps2Data   (ps2Data),
    .keyMatrix (keyMatrix),
    .keyValid  (keyValid),
    .keyCode   (keyCode),
    .keyAck    (keyAck),
    .keyOverrun(keyOverrun)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: applies the scan-code rules to one byte.
  function automatic void model_byte(input bit [7:0] b);
    bit known = key_of.exists(b);
    int k = known ? key_of[b] : 0;
    if (m_e0) begin
      if (!m_f0 && b == 8'hF0) m_f0 = 1'b1;
      else begin m_e0 = 1'b0; m_f0 = 1'b0; end
    end else if (m_f0) begin
      if (known) m_matrix[k] = 1'b0;
      m_f0 = 1'b0;
    end else if (b == 8'hF0) m_f0 = 1'b1;
    else if (b == 8'hE0) m_e0 = 1'b1;
    else if (b == 8'h00 || b == 8'hFF) m_matrix = '0;
    else if (known) begin
`ifdef PS2_KEYPAD_TYPEMATIC_FILTER_EN
      if (!m_matrix[k]) exp_q.push_back(k);
`else
      exp_q.push_back(k);
`endif
      m_matrix[k] = 1'b1;
    end
  endfunction

  task automatic send_byte(input logic [7:0] b);
    ps2Data  = b;
    ps2Ready = 1'b1;
    repeat (4) @(negedge clk);
    ps2Ready = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  // Drives keyAck exactly in the cycle the DUT strobes the byte.
  task automatic send_with_ack(input logic [7:0] b);
    ps2Data  = b;
    ps2Ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    keyAck = 1'b1;
    @(negedge clk);
    keyAck = 1'b0;
    @(negedge clk);
    ps2Ready = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic send_model(input logic [7:0] b);
    model_byte(b);
    send_byte(b);
    check($sformatf("matrix_after_%02h", b), keyMatrix, m_matrix);
    check("overrun_idle", keyOverrun, 1'b0);
  endtask

  task automatic gap(input int n);
    repeat (n) @(negedge clk);
    if (n >= TMO) begin m_f0 = 1'b0; m_e0 = 1'b0; end
  endtask

  task automatic pulse_ack();
    keyAck = 1'b1;
    @(negedge clk);
    keyAck = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    m_matrix = '0;
    m_f0 = 1'b0;
    m_e0 = 1'b0;
    exp_q.delete();
  endtask

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (mon_en && keyValid) begin
        events_seen++;
        check("event_expected", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) check("event_code", keyCode, exp_q.pop_front());
        keyAck = 1'b1;
        @(negedge clk);
        keyAck = 1'b0;
      end
    end
  end

  initial begin : stimulus
    int ev0;
    int r;
    for (int i = 0; i < 16; i++) key_of[make_codes[i]] = i;
    rst_n = 1'b0; ps2Ready = 1'b0; ps2Data = 8'h00; keyAck = 1'b0;
    repeat (4) @(negedge clk);
    check("rst_matrix", keyMatrix, 16'h0000);
    check("rst_valid", keyValid, 1'b0);
    check("rst_code", keyCode, 4'h0);
    check("rst_overrun", keyOverrun, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    // Press then release of key 1, event remains pending.
    send_byte(8'h16);
    check("t1_matrix_make", keyMatrix, 16'h0002);
    check("t1_valid", keyValid, 1'b1);
    check("t1_code", keyCode, 4'h1);
    send_byte(8'hF0);
    send_byte(8'h16);
    check("t1_matrix_break", keyMatrix, 16'h0000);
    check("t1_valid_held", keyValid, 1'b1);
    pulse_ack();
    check("t1_valid_acked", keyValid, 1'b0);

    // Handshake, overrun, and ack coinciding with a new press.
    send_byte(8'h1E);
    check("t2_code_2", keyCode, 4'h2);
    pulse_ack();
    check("t2_valid_acked", keyValid, 1'b0);
    pulse_ack();
    check("t2_stray_ack", keyValid, 1'b0);
    send_byte(8'h2A);
    check("t2_code_f", keyCode, 4'hF);
    send_byte(8'h22);
    check("t2_code_held", keyCode, 4'hF);
    check("t2_overrun", keyOverrun, 1'b1);
    send_with_ack(8'h1A);
    check("t2_ack_press_valid", keyValid, 1'b1);
    check("t2_ack_press_code", keyCode, 4'hA);
    check("t2_ack_press_ovr", keyOverrun, 1'b0);
    pulse_ack();
    check("t2_final_valid", keyValid, 1'b0);
    check("t2_matrix", keyMatrix, 16'h8405);

    do_reset();
    mon_en = 1'b1;

    // Extended keys leave the matrix alone.
    ev0 = events_seen;
    send_model(8'hE0); send_model(8'h75);
    send_model(8'hE0); send_model(8'hF0); send_model(8'h75);
    check("t3_no_ext_events", events_seen - ev0, 0);
    send_model(8'h1C);
    send_model(8'hF0); send_model(8'h1C);

    // Typematic repeats.
    ev0 = events_seen;
    repeat (4) send_model(8'h1C);
    gap(4);
`ifdef PS2_KEYPAD_TYPEMATIC_FILTER_EN
    check("t5_repeat_events", events_seen - ev0, 1);
`else
    check("t5_repeat_events", events_seen - ev0, 4);
`endif
    send_model(8'hF0); send_model(8'h1C);

    // Prefix timeout boundary: short gap keeps the break, long gap drops it.
    send_model(8'h15);
    send_model(8'hF0);
    gap(TMO - 30);
    send_model(8'h15);
    check("t4_break_kept", keyMatrix[4], 1'b0);
    send_model(8'hF0);
    gap(TMO + 10);
    send_model(8'h15);
    check("t4_break_dropped", keyMatrix[4], 1'b1);

    // Clear-all and reset in the middle of a break.
    send_model(8'h16); send_model(8'h1E);
    send_model(8'hFF);
    check("t6_cleared", keyMatrix, 16'h0000);
    send_model(8'h16);
    send_model(8'hF0);
    do_reset();
    check("t6_rst_matrix", keyMatrix, 16'h0000);
    check("t6_rst_valid", keyValid, 1'b0);
    send_model(8'h16);
    check("t6_bit1_after_reset", keyMatrix, 16'h0002);

    // Randomized byte stream against the model.
    for (int n = 0; n < 300; n++) begin
      r = $urandom_range(0, 19);
      if (r == 10 || r == 11)  send_model(8'hF0);
      else if (r == 12)        send_model(8'hE0);
      else if (r == 13)        send_model(($urandom_range(0, 3) == 0) ? 8'hFF : 8'h00);
      else if (r == 14)        send_model(($urandom_range(0, 1) == 0) ? 8'hAA : 8'hFA);
      else if (r == 15)        send_model(8'($urandom_range(0, 255)));
      else                     send_model(make_codes[$urandom_range(0, 15)]);
      if ($urandom_range(0, 39) == 0) gap(TMO + 10);
      else gap($urandom_range(0, 5));
    end

    repeat (20) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
